// File: rtl/instr_memory_banked.sv
// rtl/instr_memory_banked.sv - banked instruction store with runtime loader and handshaked bank switch
module instr_memory_banked #(
    parameter int              IW       = 9,
    parameter int              AW       = 10,
    parameter int              BANKS    = 4,
    parameter int              BW       = $clog2(BANKS),
    parameter logic [IW-1:0]   NOP_WORD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    pc,
    input  logic             fetch_en,
    output logic [IW-1:0]    instr,
    output logic             instr_valid,
    input  logic             bank_req,
    input  logic [BW-1:0]    bank_sel,
    output logic             bank_ack,
    output logic             bank_err,
    output logic [BW-1:0]    active_bank,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [BW-1:0]    ld_bank,
    input  logic [AW-1:0]    ld_addr,
    input  logic [IW-1:0]    ld_data,
    input  logic             ld_last,
    output logic [BANKS-1:0] loaded
);

    localparam int             DEPTH      = BANKS * (2 ** AW);
    localparam logic [BW:0]    BANK_LIMIT = (BW + 1)'(BANKS);

    typedef enum logic [1:0] {RUN, FLUSH, SWAP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   mem [DEPTH];
    logic [BW-1:0]   pend_bank;
    logic            ld_bank_ok, sel_ok, ld_fire, req_reject, req_go;

    assign ld_bank_ok = {1'b0, ld_bank} < BANK_LIMIT;
    assign sel_ok     = {1'b0, bank_sel} < BANK_LIMIT;
    assign ld_ready   = (state == RUN) && (ld_bank != active_bank) && ld_bank_ok;
    // Reset aborts any in-progress load: a beat in the reset cycle is dropped.
    assign ld_fire    = ld_valid && ld_ready && !reset;

    assign req_reject = (bank_sel == active_bank) || !sel_ok || !loaded[bank_sel]
                        || (ld_fire && (ld_bank == bank_sel));
    assign req_go     = (state == RUN) && bank_req && !req_reject;

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (req_go) state_nx = FLUSH;
            FLUSH:   state_nx = SWAP;
            SWAP:    state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // Memory is never cleared so images survive reset.
    always_ff @(posedge clk) begin
        if (ld_fire) mem[{ld_bank, ld_addr}] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            bank_ack    <= 1'b0;
            bank_err    <= 1'b0;
            active_bank <= '0;
            loaded      <= BANKS'(1);
            pend_bank   <= '0;
        end else begin
            instr_valid <= 1'b0;
            bank_ack    <= 1'b0;
            bank_err    <= 1'b0;
            case (state)
                RUN: begin
                    if (fetch_en) begin
                        instr       <= mem[{active_bank, pc}];
                        instr_valid <= 1'b1;
                    end
                    if (bank_req) begin
                        if (req_reject) bank_err  <= 1'b1;
                        else            pend_bank <= bank_sel;
                    end
                end
                FLUSH: instr <= NOP_WORD;
                SWAP: begin
                    active_bank <= pend_bank;
                    bank_ack    <= 1'b1;
                end
                default: ;
            endcase
            // A final beat marks the bank complete; any other beat invalidates it.
            if (ld_fire) loaded[ld_bank] <= ld_last;
        end
    end

endmodule

// File: tb/tb_instr_memory_banked.sv
// tb/tb_instr_memory_banked.sv - directed self-checking bench for instr_memory_banked
module tb_instr_memory_banked;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc;
    logic        fetch_en;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        bank_req;
    logic [1:0]  bank_sel;
    logic        bank_ack, bank_err;
    logic [1:0]  active_bank;
    logic        ld_valid, ld_ready;
    logic [1:0]  ld_bank;
    logic [9:0]  ld_addr;
    logic [8:0]  ld_data;
    logic        ld_last;
    logic [3:0]  loaded;

    int n_checks = 0;
    int n_fail   = 0;

    instr_memory_banked dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
        .instr(instr), .instr_valid(instr_valid),
        .bank_req(bank_req), .bank_sel(bank_sel), .bank_ack(bank_ack), .bank_err(bank_err),
        .active_bank(active_bank),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_bank(ld_bank), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] img(input int b, input int a);
        return 9'((b * 37 + a * 11 + 5) & 9'h1ff);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int b, input int n, input bit with_last);
        for (int a = 0; a < n; a++) begin
            ld_valid = 1'b1;
            ld_bank  = 2'(b);
            ld_addr  = 10'(a);
            ld_data  = img(b, a);
            ld_last  = with_last && (a == n - 1);
            #1;
            if (a == 0) check("ld_ready_load", 32'(ld_ready), 32'd1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic switch_to(input int b);
        bit got = 1'b0;
        bank_req = 1'b1;
        bank_sel = 2'(b);
        tick();
        bank_req = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (bank_ack) got = 1'b1;
            else tick();
        end
        check("switch_ack", 32'(got), 32'd1);
        check("switch_active", 32'(active_bank), 32'(b));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_instr"}, 32'(instr), 32'h000);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_active"}, 32'(active_bank), 32'd0);
        check({tag, "_loaded"}, 32'(loaded), 32'b0001);
        check({tag, "_ack"}, 32'(bank_ack), 32'd0);
    endtask

    initial begin
        reset = 1'b1; pc = '0; fetch_en = 1'b0; bank_req = 1'b0; bank_sel = '0;
        ld_valid = 1'b0; ld_bank = '0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_reset_state("reset");
        check("reset_err", 32'(bank_err), 32'd0);

        // Build a known bank 0 image by detouring through bank 1.
        load(1, 8, 1'b1);
        switch_to(1);
        load(0, 8, 1'b1);
        switch_to(0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("reset2");

        // Test 1: fetch pc 0..3
        fetch_en = 1'b1;
        for (int a = 0; a < 4; a++) begin
            pc = 10'(a);
            tick();
            check($sformatf("fetch_b0_%0d", a), 32'(instr), 32'(img(0, a)));
            check($sformatf("fetch_valid_%0d", a), 32'(instr_valid), 32'd1);
        end

        // Test 2: stall 3 cycles, resume
        fetch_en = 1'b0;
        pc = 10'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 32'(instr), 32'(img(0, 3)));
            check("stall_valid", 32'(instr_valid), 32'd0);
        end
        fetch_en = 1'b1;
        tick();
        check("resume_word", 32'(instr), 32'(img(0, 4)));

        // Test 3: load bank 2 and switch
        fetch_en = 1'b0;
        load(2, 8, 1'b1);
        check("loaded_0101", 32'(loaded), 32'b0101);
        fetch_en = 1'b1; pc = 10'd5; bank_req = 1'b1; bank_sel = 2'd2;
        tick();
        bank_req = 1'b0; pc = 10'd6;
        check("pre_flush_word", 32'(instr), 32'(img(0, 5)));
        tick();
        check("flush_nop", 32'(instr), 32'h000);
        check("flush_valid", 32'(instr_valid), 32'd0);
        tick();
        check("swap_nop", 32'(instr), 32'h000);
        check("swap_ack", 32'(bank_ack), 32'd1);
        check("swap_active", 32'(active_bank), 32'd2);
        pc = 10'd0;
        tick();
        check("b2_word0", 32'(instr), 32'(img(2, 0)));
        check("b2_valid", 32'(instr_valid), 32'd1);
        check("ack_pulse", 32'(bank_ack), 32'd0);

        // Test 4: unloaded and already-active selections are rejected
        pc = 10'd1; bank_req = 1'b1; bank_sel = 2'd3;
        tick();
        check("err_unloaded", 32'(bank_err), 32'd1);
        check("err_fetch", 32'(instr), 32'(img(2, 1)));
        pc = 10'd2; bank_sel = 2'd2;
        tick();
        check("err_same_bank", 32'(bank_err), 32'd1);
        bank_req = 1'b0; pc = 10'd3;
        tick();
        check("err_pulse_end", 32'(bank_err), 32'd0);
        check("err_active", 32'(active_bank), 32'd2);
        check("err_fetch2", 32'(instr), 32'(img(2, 3)));

        // Test 5: beat to active bank refused; beat colliding with request
        ld_valid = 1'b1; ld_bank = 2'd2; ld_addr = 10'd0; ld_data = 9'h1ff; ld_last = 1'b0;
        #1;
        check("ld_ready_active", 32'(ld_ready), 32'd0);
        tick();
        ld_valid = 1'b0;
        pc = 10'd0;
        tick();
        check("active_mem_kept", 32'(instr), 32'(img(2, 0)));
        load(1, 8, 1'b1);
        check("loaded_0111", 32'(loaded), 32'b0111);
        ld_valid = 1'b1; ld_bank = 2'd1; ld_addr = 10'd0; ld_data = img(1, 0);
        bank_req = 1'b1; bank_sel = 2'd1;
        tick();
        ld_valid = 1'b0; bank_req = 1'b0;
        check("err_collide", 32'(bank_err), 32'd1);
        check("collide_loaded", 32'(loaded), 32'b0101);
        check("collide_active", 32'(active_bank), 32'd2);

        // Test 6a: reset during FLUSH
        load(1, 8, 1'b1);
        bank_req = 1'b1; bank_sel = 2'd1;
        tick();
        bank_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_flush");
        tick();
        check("rst_flush_no_ack", 32'(bank_ack), 32'd0);
        check("rst_flush_active", 32'(active_bank), 32'd0);

        // Test 6b: reset mid-load of bank 1
        fetch_en = 1'b0;
        load(1, 4, 1'b0);
        ld_valid = 1'b1; ld_bank = 2'd1; ld_addr = 10'd4; ld_data = img(1, 4); ld_last = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        check_reset_state("rst_load");
        fetch_en = 1'b1; pc = 10'd2;
        tick();
        check("post_reset_b0", 32'(instr), 32'(img(0, 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
